pipelined_prefix_adder: RTL
===========================

// Module: pipelined_prefix_adder
// PURPOSE
//  Parametrised, pipelined Kogge-Stone prefix adder/subtractor with carry-in, carry-out and signed overflow.
//  Replaces chained fixed-width prefix adders. The carry is resolved across the full WIDTH in one prefix tree.
//  Sits in the datapath between valid/ready producers and consumers (ALU, accumulators).
//  Per-stage valid/ready flow control, so bubbles collapse under backpressure.
// PARAMETERS
//  WIDTH        32  operand width in bits; power of two, 8..128
//  PIPE_STAGES  2   register stages, 1..clog2(WIDTH)+1; also the latency in cycles
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block accepts operands this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in (ignored when in_sub=1)
//  in_sub     in   1      1: A-B (B inverted, carry-in forced 1)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  A+B+cin, or A-B, modulo 2^WIDTH
//  out_cout   out  1      carry out of MSB (subtract: 1 = no borrow)
//  out_ovf    out  1      two's-complement overflow = c[WIDTH] ^ c[WIDTH-1]
// BEHAVIOUR
//  - Reset (async assert, sync-safe deassert handled upstream):
//    - all stage valid bits clear; out_valid=0; out_sum=0; out_cout=0; out_ovf=0.
//    - in_ready=1 once rst_n is high.
//  - Datapath:
//    - preprocess: g_i=a_i&b'_i, p_i=a_i^b'_i, where b'=in_sub?~b:b.
//    - cin is folded in as generate at bit -1.
//    - L=clog2(WIDTH) Kogge-Stone levels.
//    - postprocess: sum_i=p_i^G[i-1:-1].
//  - Registers:
//    - the output register is always present (stage PIPE_STAGES).
//    - for k=1..PIPE_STAGES-1, a register sits after prefix level ceil(k*L/PIPE_STAGES).
//    - with PIPE_STAGES=L+1, the extra register sits after preprocess.
//  - Latency: exactly PIPE_STAGES cycles from input handshake to out_valid, with no stall.
//  - Throughput: one op per cycle with out_ready held high.
//  - Stage k register loads when (stage k empty) OR (stage k+1 loads / output handshake).
//    in_ready = load enable of stage 1 (combinational from out_ready through the chain).
//  - Ordering: results leave strictly in acceptance order. No drop, no duplication.
//  - Stall: with out_valid=1 and out_ready=0, out_* hold stable. Upstream stages keep filling until full.
//  - Full pipe with out_ready=0: in_ready=0.
//  - Simultaneous out handshake and in handshake on a full pipe: both occur; occupancy unchanged.
//  - in_valid=0: a bubble enters. It is overwritten when a downstream stage is empty.
//  - Wrap-around: result is modulo 2^WIDTH; cout/ovf report the wrap.
//  - Reset mid-operation: all in-flight ops discarded, valids clear immediately (async).
//    No output is produced for ops accepted before reset.
//  - Inputs are sampled only on handshake. X on in_a/in_b while in_valid=0 must not propagate to out_*.
// STRUCTURE
//  - Package prefix_adder_pkg:
//    - typedef struct {logic g; logic p;} gp_t;
//    - function gp_combine(gp_t hi, gp_t lo) = {hi.g|hi.p&lo.g, hi.p&lo.p};
//    - function stage_after_level(k,L,S) for register placement.
//  - Sub-module prefix_pipe_reg:
//    - one valid/ready slice (valid bit + payload, WIDTH-param payload).
//    - instantiated PIPE_STAGES times.
//  - Prefix levels are generate loops in the top module.
// TESTING
//  - W=32, S=2: a=0xFFFFFFFF, b=1, cin=0, sub=0 -> sum=0x00000000, cout=1, ovf=0; out_valid exactly 2 cycles after accept.
//  - W=32: a=0x7FFFFFFF, b=1 -> sum=0x80000000, cout=0, ovf=1. Then sub: a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0.
//  - W=8, S=4: a=0x80, b=0x80, cin=1 -> sum=0x01, cout=1, ovf=1; latency 4.
//  - Backpressure: 200 random ops, in_valid/out_ready randomised 50%.
//    Scoreboard matches order and value; out_* stable while stalled.
//    in_ready=0 only when all S stages full.
//  - Bubble collapse, S=3: fill one op, hold out_ready=0 for 5 cycles, continue offering.
//    Exactly 3 ops accepted before in_ready=0. Release yields 3 results on consecutive cycles.
//  - Reset: assert rst_n=0 with 2 ops in flight -> out_valid=0 within the same cycle.
//    After release, no stale result appears and the first new op returns with nominal latency.

Source files
------------

// File: rtl/pipelined_prefix_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
//   gp_t               : generate/propagate pair carried through the prefix tree
//   gp_combine         : prefix operator, hi group absorbs lo group
//   stage_after_level  : prefix level after which pipeline register k sits
//   reg_stage_at_level : inverse lookup, which register (0 = none) follows level m
package prefix_adder_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  // Level 0 means "straight after preprocess". With one register per level
  // available, the registers shift down by one so the first one isolates the
  // operand conditioning; otherwise they are spread evenly (ceiling).
  function automatic int stage_after_level(input int k, input int l, input int s);
    int r;
    if (s == l + 1) begin
      r = k - 1;
    end else begin
      r = (k * l + s - 1) / s;
    end
    return r;
  endfunction

  function automatic int reg_stage_at_level(input int m, input int l, input int s);
    int r;
    r = 0;
    for (int k = 1; k < s; k++) begin
      if (stage_after_level(k, l, s) == m) begin
        r = k;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prefix_pipe_reg.sv
// One valid/ready pipeline slice: a valid bit plus a DW-bit payload.
//   up_valid/up_data/up_ready : upstream side (up_ready is this slice's load enable)
//   dn_valid/dn_data/dn_ready : downstream side (dn_ready is the next load enable)
// The slice loads whenever it is empty or the downstream side takes its
// content, so bubbles are squeezed out under backpressure. The payload only
// captures on a valid transfer, keeping garbage on idle inputs out of the pipe.
module prefix_pipe_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  output logic          up_ready,
  output logic          dn_valid,
  output logic [DW-1:0] dn_data,
  input  logic          dn_ready
);

  logic          valid_r;
  logic [DW-1:0] data_r;

  assign up_ready = ~valid_r | dn_ready;
  assign dn_valid = valid_r;
  assign dn_data  = data_r;

  // Slice state: valid follows upstream on load, payload only on a real op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (up_ready) begin
      valid_r <= up_valid;
      if (up_valid) begin
        data_r <= up_data;
      end
    end
  end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with carry-in, carry-out and signed
// overflow, wrapped in per-stage valid/ready flow control.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    : operand handshake
//   in_a, in_b           : WIDTH-bit operands
//   in_cin               : carry-in, ignored when in_sub=1
//   in_sub               : 1 selects A-B
//   out_valid/out_ready  : result handshake
//   out_sum              : WIDTH-bit result modulo 2^WIDTH
//   out_cout             : carry out of the MSB (subtract: 1 = no borrow)
//   out_ovf              : two's-complement overflow
// The prefix tree works on WIDTH+1 nodes: node 0 is the carry-in (bit -1),
// node i+1 is operand bit i. PIPE_STAGES-1 registers are placed between
// prefix levels; the output register after postprocess is always present.
module pipelined_prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int NODES  = WIDTH + 1;
  localparam int MID_W  = 2 * NODES + WIDTH;
  localparam int OUT_W  = WIDTH + 2;

  typedef gp_t [NODES-1:0] gp_vec_t;

  // stage_valid_s[k] is the valid bit of register k; index 0 is the input.
  // stage_load_s[k] is the load enable of register k (k = PIPE_STAGES is the output).
  logic [PIPE_STAGES-1:0] stage_valid_s;
  logic [PIPE_STAGES:1]   stage_load_s;

  assign stage_valid_s[0] = in_valid;
  assign in_ready         = stage_load_s[1];

  for (genvar m = 0; m <= LEVELS; m++) begin : g_lvl
    localparam int RS = reg_stage_at_level(m, LEVELS, PIPE_STAGES);

    gp_vec_t          comb_s;
    gp_vec_t          fin_s;
    logic [WIDTH-1:0] p0c_s;
    logic [WIDTH-1:0] p0f_s;

    if (m == 0) begin : g_pre
      logic [WIDTH-1:0] b_eff_s;
      logic             cin_eff_s;

      // Operand conditioning: subtract inverts B and forces the carry-in,
      // which enters the tree as a pure generate at node 0.
      always_comb begin
        b_eff_s     = in_sub ? ~in_b : in_b;
        cin_eff_s   = in_sub ? 1'b1 : in_cin;
        comb_s      = '0;
        comb_s[0].g = cin_eff_s;
        comb_s[0].p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
          comb_s[i+1].g = in_a[i] & b_eff_s[i];
          comb_s[i+1].p = in_a[i] ^ b_eff_s[i];
        end
        p0c_s = in_a ^ b_eff_s;
      end
    end else begin : g_ks
      localparam int DIST = 1 << (m - 1);

      for (genvar j = 0; j < NODES; j++) begin : g_node
        if (j >= DIST) begin : g_cmb
          assign comb_s[j] = gp_combine(g_lvl[m-1].fin_s[j], g_lvl[m-1].fin_s[j-DIST]);
        end else begin : g_pass
          assign comb_s[j] = g_lvl[m-1].fin_s[j];
        end
      end
      assign p0c_s = g_lvl[m-1].p0f_s;
    end

    if (RS != 0) begin : g_reg
      logic [MID_W-1:0] reg_q_s;

      prefix_pipe_reg #(
        .DW (MID_W)
      ) u_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (stage_valid_s[RS-1]),
        .up_data  ({comb_s, p0c_s}),
        .up_ready (stage_load_s[RS]),
        .dn_valid (stage_valid_s[RS]),
        .dn_data  (reg_q_s),
        .dn_ready (stage_load_s[RS+1])
      );

      assign fin_s = reg_q_s[MID_W-1:WIDTH];
      assign p0f_s = reg_q_s[WIDTH-1:0];
    end else begin : g_wire
      assign fin_s = comb_s;
      assign p0f_s = p0c_s;
    end
  end

  logic [WIDTH-1:0] sum_s;
  logic             carry_top_s;
  logic             ovf_s;
  logic [OUT_W-1:0] out_q_s;

  // Postprocess. After LEVELS levels node i spans bits i-1..-1 for i < NODES-1,
  // so node i's group generate is the carry into bit i. The top node only
  // reaches bit 0, so the carry-in (node 0) is folded in one final step.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      sum_s[i] = g_lvl[LEVELS].p0f_s[i] ^ g_lvl[LEVELS].fin_s[i].g;
    end
    carry_top_s = g_lvl[LEVELS].fin_s[WIDTH].g
                | (g_lvl[LEVELS].fin_s[WIDTH].p & g_lvl[LEVELS].fin_s[0].g);
    ovf_s       = carry_top_s ^ g_lvl[LEVELS].fin_s[WIDTH-1].g;
  end

  prefix_pipe_reg #(
    .DW (OUT_W)
  ) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (stage_valid_s[PIPE_STAGES-1]),
    .up_data  ({sum_s, carry_top_s, ovf_s}),
    .up_ready (stage_load_s[PIPE_STAGES]),
    .dn_valid (out_valid),
    .dn_data  (out_q_s),
    .dn_ready (out_ready)
  );

  assign out_sum  = out_q_s[OUT_W-1:2];
  assign out_cout = out_q_s[1];
  assign out_ovf  = out_q_s[0];

endmodule
